// File: rtl/lock_code_entry.sv
// Pushbutton front end for the 4-bit lock: synchronize, debounce, assemble a code MSB-first.
// Optional inactivity timeout is compiled in when ENTRY_TIMEOUT_EN is defined.
module lock_code_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_zero,
    input  logic       btn_one,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] code_out,
    output logic       enter_out,
    output logic [2:0] digit_count,
    output logic       err_out
);
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int              N_BTN   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2,
        ST_SUBMIT  = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Button order in all vectors: 0 zero, 1 one, 2 enter, 3 clear.
    logic [N_BTN-1:0] w_btn_raw;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_stable;
    logic [N_BTN-1:0] r_press;
    logic [DB_W-1:0]  r_db_cnt [N_BTN];

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_sr;
    logic [3:0] w_sr_nxt;
    logic [2:0] r_count;
    logic [2:0] w_count_nxt;
    logic [3:0] r_code;
    logic [3:0] w_code_nxt;
    logic       r_enter;
    logic       w_enter_nxt;
    logic       r_err;
    logic       w_err_nxt;

    logic w_clr;
    logic w_ent;
    logic w_dig;
    logic w_bit;
    logic w_timeout;

    assign w_btn_raw = {btn_clear, btn_enter, btn_one, btn_zero};

    // Two-flop synchronizers for the raw asynchronous buttons
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: flip the stable level after DEBOUNCE_CYCLES disagreeing samples; pulse on rise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable <= 4'b0000;
            r_press  <= 4'b0000;
            for (int i = 0; i < N_BTN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db_cnt[i] <= '0;
                        r_stable[i] <= r_sync2[i];
                        r_press[i]  <= r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                        r_press[i]  <= 1'b0;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                    r_press[i]  <= 1'b0;
                end
            end
        end
    end

    // Simultaneous zero and one cancel each other out.
    assign w_clr = r_press[3];
    assign w_ent = r_press[2];
    assign w_dig = r_press[0] ^ r_press[1];
    assign w_bit = r_press[1];

`ifdef ENTRY_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_idle_cnt;
    logic            w_active;
    logic            w_event;

    assign w_active  = (r_state == ST_COLLECT) || (r_state == ST_FULL);
    assign w_event   = w_clr | w_ent | (w_dig & (r_state != ST_FULL));
    assign w_timeout = w_active & ~w_event & (r_idle_cnt == TO_LAST);

    // Inactivity counter for a partial entry; any accepted event restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (!w_active || w_event || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, priority clear > enter > timeout > digit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_clr || w_ent || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_dig) begin
                    w_state_nxt = (r_count == 3'd3) ? ST_FULL : ST_COLLECT;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FULL: begin
                if (w_clr || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ent) begin
                    w_state_nxt = ST_SUBMIT;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_SUBMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values; the code is loaded as the FSM enters SUBMIT
    always_comb begin
        w_sr_nxt    = r_sr;
        w_count_nxt = r_count;
        w_code_nxt  = r_code;
        w_enter_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (w_clr) begin
                    w_sr_nxt    = 4'b0000;
                    w_count_nxt = 3'd0;
                end else if (w_ent || w_timeout) begin
                    w_sr_nxt    = 4'b0000;
                    w_count_nxt = 3'd0;
                    w_err_nxt   = 1'b1;
                end else if (w_dig) begin
                    w_sr_nxt    = {r_sr[2:0], w_bit};
                    w_count_nxt = r_count + 3'd1;
                end else begin
                    w_sr_nxt    = r_sr;
                    w_count_nxt = r_count;
                end
            end
            ST_FULL: begin
                if (w_clr) begin
                    w_sr_nxt    = 4'b0000;
                    w_count_nxt = 3'd0;
                end else if (w_ent) begin
                    w_code_nxt  = r_sr;
                    w_enter_nxt = 1'b1;
                end else if (w_timeout) begin
                    w_sr_nxt    = 4'b0000;
                    w_count_nxt = 3'd0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_sr_nxt    = r_sr;
                    w_count_nxt = r_count;
                end
            end
            ST_SUBMIT: begin
                w_sr_nxt    = 4'b0000;
                w_count_nxt = 3'd0;
            end
            default: begin
                w_sr_nxt    = 4'b0000;
                w_count_nxt = 3'd0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr    <= 4'b0000;
            r_count <= 3'd0;
            r_code  <= 4'b0000;
            r_enter <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sr    <= w_sr_nxt;
            r_count <= w_count_nxt;
            r_code  <= w_code_nxt;
            r_enter <= w_enter_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign code_out    = r_code;
    assign enter_out   = r_enter;
    assign digit_count = r_count;
    assign err_out     = r_err;

endmodule

// File: tb/tb_lock_code_entry.sv
// Self-checking bench for lock_code_entry (D=4, TIMEOUT=50): window-based debounce model,
// integer code model, per-cycle compare plus directed literal checks and random stimulus.
module tb_lock_code_entry;
    localparam int D = 4;
    localparam int T = 50;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] code_out;
    logic       enter_out;
    logic [2:0] digit_count;
    logic       err_out;

    int n_tests = 0;
    int n_fail  = 0;

    lock_code_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_zero    (btn[0]),
        .btn_one     (btn[1]),
        .btn_enter   (btn[2]),
        .btn_clear   (btn[3]),
        .code_out    (code_out),
        .enter_out   (enter_out),
        .digit_count (digit_count),
        .err_out     (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw-sample history per button, integer code value and digit count.
    bit         hist [4][D+2];
    bit         m_stable [4];
    bit         m_pend [4];
    int         m_count, m_val, m_idle;
    bit         m_submit, m_valid;
    logic [3:0] exp_code;
    logic       exp_enter, exp_err;
    int         exp_count;

    always @(posedge clk) begin : model
        bit clr, ent, dig, nb, accepted, active, flip;
        if (reset) begin
            m_valid = 1'b1;
            for (int b = 0; b < 4; b++) begin
                for (int i = 0; i < D + 2; i++) hist[b][i] = 1'b0;
                m_stable[b] = 1'b0;
                m_pend[b]   = 1'b0;
            end
            m_count = 0; m_val = 0; m_idle = 0; m_submit = 1'b0;
            exp_code = 4'h0; exp_enter = 1'b0; exp_err = 1'b0; exp_count = 0;
        end else begin
            clr = m_pend[3]; ent = m_pend[2];
            dig = m_pend[0] ^ m_pend[1]; nb = m_pend[1];
            exp_enter = 1'b0; exp_err = 1'b0; accepted = 1'b0;
            active = (m_count >= 1) && !m_submit;
            if (m_submit) begin
                m_submit = 1'b0; m_count = 0; m_val = 0;
            end else if (clr) begin
                m_count = 0; m_val = 0; accepted = 1'b1;
            end else if (ent) begin
                accepted = 1'b1;
                if (m_count == 4) begin
                    exp_code = 4'(m_val); exp_enter = 1'b1; m_submit = 1'b1;
                end else begin
                    exp_err = 1'b1; m_count = 0; m_val = 0;
                end
            end else if (dig && m_count < 4) begin
                m_val = m_val * 2 + int'(nb); m_count++; accepted = 1'b1;
            end
`ifdef ENTRY_TIMEOUT_EN
            if (!active || accepted) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == T) begin
                    m_idle = 0; m_count = 0; m_val = 0; exp_err = 1'b1;
                end
            end
`endif
            exp_count = m_count;
            // Stable level flips when the D samples two edges old and older all disagree.
            for (int b = 0; b < 4; b++) begin
                for (int i = D + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = btn[b];
                flip = 1'b1;
                for (int i = 2; i <= D + 1; i++) if (hist[b][i] == m_stable[b]) flip = 1'b0;
                m_pend[b] = 1'b0;
                if (flip) begin
                    m_stable[b] = !m_stable[b];
                    m_pend[b]   = m_stable[b];
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("code_out",    32'(code_out),    32'(exp_code));
            check("enter_out",   32'(enter_out),   32'(exp_enter));
            check("digit_count", 32'(digit_count), 32'(exp_count));
            check("err_out",     32'(err_out),     32'(exp_err));
        end
    end

    // Strobe/error monitors for directed checks
    int         n_strobe = 0;
    int         n_err    = 0;
    logic [3:0] last_code = 4'h0;
    always @(negedge clk) begin
        if (enter_out === 1'b1) begin n_strobe++; last_code = code_out; end
        if (err_out === 1'b1) n_err++;
    end

    task automatic press(input int b);
        @(negedge clk); btn[b] = 1'b1;
        repeat (10) @(negedge clk);
        btn[b] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic digits(input logic [3:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) press(v[i] ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, edges, dur[4], pct[4];
        bit found;
        reset = 1'b1; btn = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset code_out", 32'(code_out), 32'h0);
        check("reset digit_count", 32'(digit_count), 32'h0);

        // 1,0,1,0 then enter
        s0 = n_strobe; e0 = n_err;
        digits(4'b1010, 4);
        check("four digits count", 32'(digit_count), 32'd4);
        press(2);
        check("submit strobe cycles", 32'(n_strobe - s0), 32'd1);
        check("submit code", 32'(last_code), 32'hA);
        check("submit count zero", 32'(digit_count), 32'd0);
        check("submit no err", 32'(n_err - e0), 32'd0);

        // Bouncing one button, then held: one digit, accepted 6 edges after surviving rise
        @(negedge clk);
        btn[1] = 1'b1; repeat (2) @(negedge clk);
        btn[1] = 1'b0; repeat (2) @(negedge clk);
        btn[1] = 1'b1; repeat (2) @(negedge clk);
        btn[1] = 1'b0; repeat (2) @(negedge clk);
        btn[1] = 1'b1;
        found = 1'b0; edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!found && digit_count == 3'd1) begin edges = i - 1; found = 1'b1; end
        end
        btn[1] = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce latency", 32'(edges), 32'd6);
        check("bounce one digit", 32'(digit_count), 32'd1);
        press(3);
        check("clear count", 32'(digit_count), 32'd0);

        // Incomplete submit
        s0 = n_strobe; e0 = n_err;
        digits(4'b0101, 3);
        press(2);
        check("short err cycles", 32'(n_err - e0), 32'd1);
        check("short no strobe", 32'(n_strobe - s0), 32'd0);
        check("short count", 32'(digit_count), 32'd0);
        check("short code kept", 32'(code_out), 32'hA);

        // Fifth digit ignored
        s0 = n_strobe;
        digits(4'b0110, 4);
        press(1);
        check("fifth ignored", 32'(digit_count), 32'd4);
        press(2);
        check("fifth strobe", 32'(n_strobe - s0), 32'd1);
        check("fifth code", 32'(last_code), 32'h6);

        // Clear and enter in the same cycle
        s0 = n_strobe; e0 = n_err;
        digits(4'b1001, 4);
        @(negedge clk); btn[2] = 1'b1; btn[3] = 1'b1;
        repeat (10) @(negedge clk);
        btn[2] = 1'b0; btn[3] = 1'b0;
        repeat (10) @(negedge clk);
        check("clr+ent no strobe", 32'(n_strobe - s0), 32'd0);
        check("clr+ent no err", 32'(n_err - e0), 32'd0);
        check("clr+ent count", 32'(digit_count), 32'd0);
        check("clr+ent code", 32'(code_out), 32'h6);

        // Idle partial entry
        e0 = n_err;
        digits(4'b0011, 2);
        repeat (T) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
        check("timeout err", 32'(n_err - e0), 32'd1);
        check("timeout count", 32'(digit_count), 32'd0);
`else
        check("no timeout err", 32'(n_err - e0), 32'd0);
        check("no timeout count", 32'(digit_count), 32'd2);
`endif
        press(3);

        // Reset mid-entry, then a normal entry
        digits(4'b0111, 3);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rst code", 32'(code_out), 32'h0);
        check("rst count", 32'(digit_count), 32'd0);
        check("rst enter", 32'(enter_out), 32'd0);
        check("rst err", 32'(err_out), 32'd0);
        s0 = n_strobe;
        digits(4'b1101, 4);
        press(2);
        check("post-rst strobe", 32'(n_strobe - s0), 32'd1);
        check("post-rst code", 32'(last_code), 32'hD);

        // Random button activity, checked cycle by cycle against the model
        pct[0] = 40; pct[1] = 40; pct[2] = 15; pct[3] = 6;
        for (int b = 0; b < 4; b++) dur[b] = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < 4; b++) begin
                if (dur[b] == 0) begin
                    btn[b] = ($urandom_range(0, 99) < pct[b]);
                    dur[b] = $urandom_range(1, 14);
                end else begin
                    dur[b]--;
                end
            end
        end
        reset = 1'b0; btn = 4'b0000;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
